ram_interface: RTL and testbench



---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_interface.sv | 51 +++++
 tb/tb_ram_interface.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared widths and word/address types for the RAM block.
package ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 16;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/ram_interface.sv
// Single-clock RAM with a write port and a registered read port.
// Reads see the pre-write contents on a same-address collision.
module ram_interface
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ram_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // Whole array is flop-based so reset can clear it without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_enb) begin
      r_mem[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_enb;
      if (rd_enb) begin
        r_data <= r_mem[rd_addr];
      end
    end
  end

  assign data_out = r_data;
  assign rd_valid = r_valid;

endmodule

// File: tb/tb_ram_interface.sv
// Self-checking bench for ram_interface: vector table, directed
// corner sequences and randomized traffic against an array model.
module tb_ram_interface;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_enb = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          rd_enb = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid;

  ram_interface dut (
    .clk      (clk),
    .rst      (rst),
    .wr_enb   (wr_enb),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .rd_enb   (rd_enb),
    .rd_addr  (rd_addr),
    .data_out (data_out),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem [DP];
  logic [DW-1:0] m_data;
  logic          m_valid;

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic          rd;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    m_data  = '0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle, advance model by one clock edge, sample 1ns later.
  task automatic cycle(input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d, input logic r,
                       input logic [AW-1:0] ra);
    wr_enb  = w;
    wr_addr = wa;
    data_in = d;
    rd_enb  = r;
    rd_addr = ra;
    @(posedge clk);
    m_valid = r;
    if (r) m_data = m_mem[ra];
    if (w) m_mem[wa] = d;
    #1;
  endtask

  task automatic chk_model(string name);
    chk({name, ".data"}, 32'(data_out), 32'(m_data));
    chk({name, ".valid"}, 32'(rd_valid), 32'(m_valid));
  endtask

  // Reset asserted mid-cycle, with write/read attempts held during reset.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst.data_now", 32'(data_out), 32'h0);
    chk("rst.valid_now", 32'(rd_valid), 32'h0);
    wr_enb  = 1'b1;
    wr_addr = 4'd5;
    data_in = 8'h77;
    rd_enb  = 1'b1;
    rd_addr = 4'd5;
    @(posedge clk);
    #1;
    chk("rst.hold_data", 32'(data_out), 32'h0);
    chk("rst.hold_valid", 32'(rd_valid), 32'h0);
    #2 rst = 1'b1;
    wr_enb = 1'b0;
    rd_enb = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 4'd7, 8'h11, 1'b0, 4'd0, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 4'd7, 8'h22, 1'b1, 4'd7, 1'b1, 8'h11};
    vecs[5] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 8'h22};
    vecs[6] = '{1'b0, 4'd9, 8'h3C, 1'b0, 4'd0, 1'b0, 8'h22};
    vecs[7] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b1, 8'h00};
    vecs[8] = '{1'b1, 4'd2, 8'h66, 1'b1, 4'd3, 1'b1, 8'hA5};
    vecs[9] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 8'h66};

    model_reset();
    do_reset();

    // Reset state read-back and the held write being ignored
    cycle(1'b0, '0, '0, 1'b1, 4'd5);
    chk("reset.read5_data", 32'(data_out), 32'h00);
    chk("reset.read5_valid", 32'(rd_valid), 32'h1);

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].wr, vecs[i].wa, vecs[i].d, vecs[i].rd, vecs[i].ra);
      chk($sformatf("vec%0d.data", i), 32'(data_out), 32'(vecs[i].ed));
      chk($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(vecs[i].ev));
    end

    // Full sweep: write all, then back-to-back reads with no gaps
    for (int a = 0; a < DP; a++) begin
      cycle(1'b1, AW'(a), DW'(a) ^ 8'h5A, 1'b0, '0);
    end
    for (int a = 0; a < DP; a++) begin
      cycle(1'b0, '0, '0, 1'b1, AW'(a));
      chk($sformatf("sweep%0d.data", a), 32'(data_out), 32'(DW'(a) ^ 8'h5A));
      chk($sformatf("sweep%0d.valid", a), 32'(rd_valid), 32'h1);
    end
    cycle(1'b0, '0, '0, 1'b0, '0);
    chk("sweep.end_valid", 32'(rd_valid), 32'h0);

    // Async reset between edges while a read result is on the output
    cycle(1'b1, 4'd0, 8'hFF, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 4'd0);
    chk("midrd.pre_data", 32'(data_out), 32'hFF);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("midrd.async_data", 32'(data_out), 32'h0);
    chk("midrd.async_valid", 32'(rd_valid), 32'h0);
    #2 rst = 1'b1;
    rd_enb = 1'b0;
    cycle(1'b0, '0, '0, 1'b1, 4'd0);
    chk("midrd.after_data", 32'(data_out), 32'h00);
    chk("midrd.after_valid", 32'(rd_valid), 32'h1);

    // Randomized traffic against the model, with one reset midway
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      cycle(1'($urandom), AW'($urandom), DW'($urandom),
            1'($urandom), AW'($urandom));
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
